riscv_core_div_ctrl: RTL and testbench
======================================

# riscv_core_div_ctrl

Issue/sequencing controller that sits directly upstream of `riscv_core_div` in the M-extension execute path. It accepts divide requests from the execute stage and registers and holds the operands for the divider. It drives the divider enable, stalls the pipeline until the divider reports done, and returns a registered result. It also resolves divide-by-zero locally without launching the divider, survives pipeline flushes mid-operation by draining the divider, and flags a hung divider through a watchdog.

## Interface
- `XLEN`, 64, datapath width.
- `TIMEOUT`, 80, maximum busy cycles allowed before the watchdog fires; must be at least 2.

Ports:
- `i_div_ctrl_clk`  in  1  clock; all state updates on the rising edge.
- `i_div_ctrl_rstn`  in  1  asynchronous, active-low reset.
- `i_div_ctrl_valid`  in  1  execute stage presents a divide op; held with stable operands while `o_div_ctrl_stall` is high.
- `i_div_ctrl_srcA`  in  XLEN  dividend operand.
- `i_div_ctrl_srcB`  in  XLEN  divisor operand.
- `i_div_ctrl_control`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `i_div_ctrl_isword`  in  1  W-variant; uses the low 32 bits and sign-extends the result.
- `i_div_ctrl_flush`  in  1  kills the instruction currently in execute.
- `i_div_ctrl_done`  in  1  done from the divider.
- `i_div_ctrl_result`  in  XLEN  result from the divider; valid while done is high.
- `o_div_ctrl_srcA`, `o_div_ctrl_srcB`  out  XLEN  registered operands to the divider.
- `o_div_ctrl_control`  out  2  registered operation code to the divider.
- `o_div_ctrl_isword`  out  1  registered W flag to the divider.
- `o_div_ctrl_en`  out  1  divider enable; high throughout BUSY and DRAIN.
- `o_div_ctrl_stall`  out  1  combinational pipeline stall.
- `o_div_ctrl_valid`  out  1  one-cycle result-valid pulse.
- `o_div_ctrl_result`  out  XLEN  registered result.
- `o_div_ctrl_timeout`  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- **States:** IDLE, BUSY, DRAIN, RESP. Reset places the block in IDLE; every output register resets to 0.
- **Zero divisor:** detected when `srcB == 0`, or when `srcB[31:0] == 0` and `isword` is high.
- **IDLE, valid and not flush, nonzero divisor:** capture srcA, srcB, control and isword; clear the busy counter; go to BUSY.
- **IDLE, valid and not flush, zero divisor:** load the result register and go to RESP. The divider is never enabled.
  - DIV/DIVU: result = all ones.
  - REM/REMU: result = srcA, or sign-extended `srcA[31:0]` when `isword` is high.
- **IDLE, valid and flush:** ignore the request.
- **BUSY:** the counter increments each cycle.
  - done and not flush: register `i_div_ctrl_result`; go to RESP.
  - flush and not done: go to DRAIN.
  - flush and done in the same cycle: discard the result; go to IDLE.
  - counter reaches TIMEOUT-1 without done: set timeout, load result 0, go to RESP.
- **DRAIN:** the enable stays high and the counter keeps running.
  - done: go to IDLE with no valid pulse.
  - counter reaches TIMEOUT-1: set timeout; go to IDLE.
- **RESP:** assert `o_div_ctrl_valid` unless flush is high this cycle; go to IDLE. `i_div_ctrl_valid` is ignored in RESP because it still belongs to the completed instruction.
- **Stall equation:** `stall = (IDLE & valid & ~flush) | (BUSY & ~flush) | (DRAIN & valid)`. Stall is low in RESP.
- The operand registers to the divider change only on entry to BUSY and are stable through BUSY and DRAIN.
- `o_div_ctrl_result` holds its value until the next load.

## Timing
- Request accepted in cycle 0, stall high. `o_div_ctrl_en` is high from cycle 1.
- Divider done in cycle N gives RESP in cycle N+1, with `o_div_ctrl_valid` = 1 and stall low.
- Zero divisor: stall in cycle 0, result in cycle 1. Total latency is 2 cycles including accept.
- Flush in BUSY: stall drops in the same cycle, because the flush term is combinational. `o_div_ctrl_en` drops the cycle after done arrives in DRAIN.
- A new request arriving during DRAIN stalls. It is accepted in the IDLE cycle that follows DRAIN.
- Reset mid-operation: asynchronous return to IDLE, `en` and `valid` at 0 immediately, and the timeout flag cleared. The divider is reset by the same reset line.
- Back-to-back requests: the minimum spacing is one IDLE cycle after RESP.

## Test plan
- **Unsigned divide:** DIVU, srcA=100, srcB=7; divider model returns 14 with done at cycle 65. Required: `o_div_ctrl_en` high cycles 1–65, stall high cycles 0–65, valid pulse with result 14 in cycle 66.
- **Divide by zero, 64-bit:** DIV, srcA=5, srcB=0. Required: `en` never asserts, valid in cycle 1, result 0xFFFF_FFFF_FFFF_FFFF. REMU with the same operands gives result 5.
- **Divide by zero, word:** REMW, srcA=0x0000_0001_8000_0000, srcB=0x0000_0002_0000_0000. Required: result 0xFFFF_FFFF_8000_0000, no enable.
- **Flush while busy:** flush in cycle 10 of BUSY, then a new DIV request in cycle 12, with divider done at cycle 40. Required: no valid pulse for the flushed op, stall high cycles 12–40, new op accepted in cycle 41.
- **Watchdog:** divider never asserts done. Required: at busy count TIMEOUT-1 the timeout flag sets and a valid pulse with result 0 follows; the flag stays set until reset.
- **Reset mid-operation:** reset asserted in cycle 20 of BUSY. Required: all outputs 0 asynchronously; after release, an IDLE accept works normally.

Source files
------------

// File: rtl/riscv_core_div_ctrl_if.sv
// rtl/riscv_core_div_ctrl_if.sv - execute-stage and divider-side signal bundle for riscv_core_div_ctrl
//
// Purpose: groups every non-clock/reset signal of the divide controller.
//   slave  : the controller view (i_* in, o_* out)
//   master : the surrounding pipeline/divider view (i_* out, o_* in)
// Signals:
//   i_div_ctrl_valid/srcA/srcB/control/isword/flush : execute-stage request
//   i_div_ctrl_done/result                          : divider completion
//   o_div_ctrl_srcA/srcB/control/isword/en          : registered divider drive
//   o_div_ctrl_stall/valid/result/timeout           : pipeline response
interface riscv_core_div_ctrl_if #(
  parameter int XLEN = 64
);
  logic            i_div_ctrl_valid;
  logic [XLEN-1:0] i_div_ctrl_srcA;
  logic [XLEN-1:0] i_div_ctrl_srcB;
  logic [1:0]      i_div_ctrl_control;
  logic            i_div_ctrl_isword;
  logic            i_div_ctrl_flush;
  logic            i_div_ctrl_done;
  logic [XLEN-1:0] i_div_ctrl_result;
  logic [XLEN-1:0] o_div_ctrl_srcA;
  logic [XLEN-1:0] o_div_ctrl_srcB;
  logic [1:0]      o_div_ctrl_control;
  logic            o_div_ctrl_isword;
  logic            o_div_ctrl_en;
  logic            o_div_ctrl_stall;
  logic            o_div_ctrl_valid;
  logic [XLEN-1:0] o_div_ctrl_result;
  logic            o_div_ctrl_timeout;

  modport slave (
    input  i_div_ctrl_valid, i_div_ctrl_srcA, i_div_ctrl_srcB, i_div_ctrl_control,
           i_div_ctrl_isword, i_div_ctrl_flush, i_div_ctrl_done, i_div_ctrl_result,
    output o_div_ctrl_srcA, o_div_ctrl_srcB, o_div_ctrl_control, o_div_ctrl_isword,
           o_div_ctrl_en, o_div_ctrl_stall, o_div_ctrl_valid, o_div_ctrl_result,
           o_div_ctrl_timeout
  );

  modport master (
    output i_div_ctrl_valid, i_div_ctrl_srcA, i_div_ctrl_srcB, i_div_ctrl_control,
           i_div_ctrl_isword, i_div_ctrl_flush, i_div_ctrl_done, i_div_ctrl_result,
    input  o_div_ctrl_srcA, o_div_ctrl_srcB, o_div_ctrl_control, o_div_ctrl_isword,
           o_div_ctrl_en, o_div_ctrl_stall, o_div_ctrl_valid, o_div_ctrl_result,
           o_div_ctrl_timeout
  );
endinterface

// File: rtl/riscv_core_div_ctrl.sv
// rtl/riscv_core_div_ctrl.sv - divide issue/sequencing controller ahead of riscv_core_div
//
// Purpose: accepts a divide op from execute, holds operands for the divider,
//   stalls until done, returns a registered result, resolves divide-by-zero
//   locally, drains the divider after a flush and flags a hung divider.
// Ports:
//   i_div_ctrl_clk  : clock
//   i_div_ctrl_rstn : asynchronous active-low reset
//   bus             : riscv_core_div_ctrl_if slave view (request, divider, response)
module riscv_core_div_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 80
) (
  input  logic                  i_div_ctrl_clk,
  input  logic                  i_div_ctrl_rstn,
  riscv_core_div_ctrl_if.slave  bus
);
  // One extra count of headroom: a flush landing on the last BUSY cycle
  // enters DRAIN with the counter already at TIMEOUT.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_RESP} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] srca_q;
  logic [XLEN-1:0] srcb_q;
  logic [1:0]      control_q;
  logic            isword_q;
  logic            en_q;
  logic [XLEN-1:0] result_q;
  logic            timeout_q;

  logic            accept;
  logic            zero_div;
  logic            cnt_expired;
  logic [XLEN-1:0] zero_result;

  assign accept      = bus.i_div_ctrl_valid & ~bus.i_div_ctrl_flush;
  assign zero_div    = (bus.i_div_ctrl_srcB == '0) |
                       (bus.i_div_ctrl_isword & (bus.i_div_ctrl_srcB[31:0] == 32'd0));
  assign cnt_expired = (cnt_q >= CW'(TIMEOUT - 1));

  // RISC-V divide-by-zero: quotient all ones, remainder is the dividend.
  always_comb begin
    zero_result = '1;
    if (bus.i_div_ctrl_control[1]) begin
      if (bus.i_div_ctrl_isword) begin
        zero_result = {{(XLEN-32){bus.i_div_ctrl_srcA[31]}}, bus.i_div_ctrl_srcA[31:0]};
      end else begin
        zero_result = bus.i_div_ctrl_srcA;
      end
    end
  end

  always_ff @(posedge i_div_ctrl_clk or negedge i_div_ctrl_rstn) begin
    if (!i_div_ctrl_rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      srca_q    <= '0;
      srcb_q    <= '0;
      control_q <= 2'b00;
      isword_q  <= 1'b0;
      en_q      <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (zero_div) begin
              result_q <= zero_result;
              state_q  <= S_RESP;
            end else begin
              srca_q    <= bus.i_div_ctrl_srcA;
              srcb_q    <= bus.i_div_ctrl_srcB;
              control_q <= bus.i_div_ctrl_control;
              isword_q  <= bus.i_div_ctrl_isword;
              cnt_q     <= '0;
              en_q      <= 1'b1;
              state_q   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus.i_div_ctrl_done && bus.i_div_ctrl_flush) begin
            en_q    <= 1'b0;
            state_q <= S_IDLE;
          end else if (bus.i_div_ctrl_done) begin
            result_q <= bus.i_div_ctrl_result;
            en_q     <= 1'b0;
            state_q  <= S_RESP;
          end else if (bus.i_div_ctrl_flush) begin
            // Divider must finish (or time out) before it can take new operands.
            state_q <= S_DRAIN;
          end else if (cnt_expired) begin
            timeout_q <= 1'b1;
            result_q  <= '0;
            en_q      <= 1'b0;
            state_q   <= S_RESP;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus.i_div_ctrl_done) begin
            en_q    <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_expired) begin
            timeout_q <= 1'b1;
            en_q      <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_RESP: begin
          // Incoming valid still belongs to the instruction just completed.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_div_ctrl_srcA    = srca_q;
  assign bus.o_div_ctrl_srcB    = srcb_q;
  assign bus.o_div_ctrl_control = control_q;
  assign bus.o_div_ctrl_isword  = isword_q;
  assign bus.o_div_ctrl_en      = en_q;
  assign bus.o_div_ctrl_result  = result_q;
  assign bus.o_div_ctrl_timeout = timeout_q;

  assign bus.o_div_ctrl_stall = ((state_q == S_IDLE)  & accept) |
                                ((state_q == S_BUSY)  & ~bus.i_div_ctrl_flush) |
                                ((state_q == S_DRAIN) & bus.i_div_ctrl_valid);

  assign bus.o_div_ctrl_valid = (state_q == S_RESP) & ~bus.i_div_ctrl_flush;
endmodule

// File: tb/tb_riscv_core_div_ctrl.sv
// tb/tb_riscv_core_div_ctrl.sv - scoreboard testbench for riscv_core_div_ctrl
module tb_riscv_core_div_ctrl;
  localparam int XLEN    = 64;
  localparam int TIMEOUT = 80;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  riscv_core_div_ctrl_if #(.XLEN(XLEN)) bus ();

  riscv_core_div_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .i_div_ctrl_clk  (clk),
    .i_div_ctrl_rstn (rstn),
    .bus             (bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  logic [63:0] sb[$];

  task automatic idle_inputs();
    bus.i_div_ctrl_valid   = 1'b0;
    bus.i_div_ctrl_srcA    = '0;
    bus.i_div_ctrl_srcB    = '0;
    bus.i_div_ctrl_control = 2'b00;
    bus.i_div_ctrl_isword  = 1'b0;
    bus.i_div_ctrl_flush   = 1'b0;
    bus.i_div_ctrl_done    = 1'b0;
    bus.i_div_ctrl_result  = '0;
  endtask

  // lat == 0: zero-divisor path (RESP in cycle 1, divider never enabled).
  // lat  > 0: divider done in cycle lat, RESP in cycle lat+1.
  task automatic run_op(string nm, logic [1:0] ctrl, logic w, logic [63:0] a, logic [63:0] b,
                        int lat, logic [63:0] dres, logic [63:0] exp);
    int resp;
    logic [63:0] want;
    resp = (lat == 0) ? 1 : lat + 1;
    bus.i_div_ctrl_srcA    = a;
    bus.i_div_ctrl_srcB    = b;
    bus.i_div_ctrl_control = ctrl;
    bus.i_div_ctrl_isword  = w;
    sb.push_back(exp);
    for (int c = 0; c <= resp + 1; c++) begin
      bus.i_div_ctrl_valid  = (c < resp);
      bus.i_div_ctrl_done   = (lat != 0) && (c == lat);
      bus.i_div_ctrl_result = bus.i_div_ctrl_done ? dres : 64'h0BAD_0BAD_0BAD_0BAD;
      #1;
      n_run++;
      if (bus.o_div_ctrl_en !== ((lat != 0) && c >= 1 && c <= lat)) begin
        n_fail++; $display("FAIL %s_en cycle %0d: got %b", nm, c, bus.o_div_ctrl_en);
      end
      n_run++;
      if (bus.o_div_ctrl_stall !== (c < resp)) begin
        n_fail++; $display("FAIL %s_stall cycle %0d: got %b", nm, c, bus.o_div_ctrl_stall);
      end
      n_run++;
      if (bus.o_div_ctrl_valid !== (c == resp)) begin
        n_fail++; $display("FAIL %s_valid cycle %0d: got %b want %b", nm, c, bus.o_div_ctrl_valid, c == resp);
      end
      if (bus.o_div_ctrl_valid === 1'b1 && sb.size() > 0) begin
        want = sb.pop_front();
        n_run++;
        if (bus.o_div_ctrl_result !== want) begin
          n_fail++; $display("FAIL %s_result: got %h want %h", nm, bus.o_div_ctrl_result, want);
        end
      end
      if (lat != 0 && c == 1) begin
        n_run++;
        if (bus.o_div_ctrl_srcA !== a || bus.o_div_ctrl_srcB !== b ||
            bus.o_div_ctrl_control !== ctrl || bus.o_div_ctrl_isword !== w) begin
          n_fail++; $display("FAIL %s_operands: got %h %h %b %b want %h %h %b %b", nm,
            bus.o_div_ctrl_srcA, bus.o_div_ctrl_srcB, bus.o_div_ctrl_control, bus.o_div_ctrl_isword,
            a, b, ctrl, w);
        end
      end
      @(negedge clk);
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL %s_sb_empty: got %0d pending want 0", nm, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk); @(negedge clk);
    n_run++;
    if ({bus.o_div_ctrl_en, bus.o_div_ctrl_stall, bus.o_div_ctrl_valid, bus.o_div_ctrl_timeout,
         bus.o_div_ctrl_isword, bus.o_div_ctrl_control} !== 7'b0 ||
        bus.o_div_ctrl_result !== 64'd0 || bus.o_div_ctrl_srcA !== 64'd0 || bus.o_div_ctrl_srcB !== 64'd0) begin
      n_fail++; $display("FAIL reset_outputs: got en=%b stall=%b valid=%b to=%b result=%h want all 0",
        bus.o_div_ctrl_en, bus.o_div_ctrl_stall, bus.o_div_ctrl_valid, bus.o_div_ctrl_timeout,
        bus.o_div_ctrl_result);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu();
    run_op("divu", 2'b01, 1'b0, 64'd100, 64'd7, 65, 64'd14, 64'd14);
  endtask

  task automatic test_div_zero();
    run_op("div_zero", 2'b00, 1'b0, 64'd5, 64'd0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_zero", 2'b11, 1'b0, 64'd5, 64'd0, 0, 64'd0, 64'd5);
  endtask

  task automatic test_word_zero();
    run_op("remw_zero", 2'b10, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0002_0000_0000,
           0, 64'd0, 64'hFFFF_FFFF_8000_0000);
  endtask

  task automatic test_watchdog();
    logic [63:0] want;
    bus.i_div_ctrl_srcA    = 64'd1;
    bus.i_div_ctrl_srcB    = 64'd1;
    bus.i_div_ctrl_control = 2'b01;
    bus.i_div_ctrl_isword  = 1'b0;
    bus.i_div_ctrl_done    = 1'b0;
    sb.push_back(64'd0);
    for (int c = 0; c <= TIMEOUT + 4; c++) begin
      bus.i_div_ctrl_valid = (c <= TIMEOUT);
      #1;
      n_run++;
      if (bus.o_div_ctrl_en !== (c >= 1 && c <= TIMEOUT)) begin
        n_fail++; $display("FAIL wd_en cycle %0d: got %b", c, bus.o_div_ctrl_en);
      end
      n_run++;
      if (bus.o_div_ctrl_timeout !== (c >= TIMEOUT + 1)) begin
        n_fail++; $display("FAIL wd_timeout cycle %0d: got %b", c, bus.o_div_ctrl_timeout);
      end
      n_run++;
      if (bus.o_div_ctrl_valid !== (c == TIMEOUT + 1)) begin
        n_fail++; $display("FAIL wd_valid cycle %0d: got %b", c, bus.o_div_ctrl_valid);
      end
      if (bus.o_div_ctrl_valid === 1'b1 && sb.size() > 0) begin
        want = sb.pop_front();
        n_run++;
        if (bus.o_div_ctrl_result !== want) begin
          n_fail++; $display("FAIL wd_result: got %h want %h", bus.o_div_ctrl_result, want);
        end
      end
      @(negedge clk);
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL wd_sb_empty: got %0d pending want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [63:0] want;
    for (int c = 0; c <= 4; c++) begin
      if (c == 0) begin
        bus.i_div_ctrl_valid = 1'b1; bus.i_div_ctrl_control = 2'b11;
        bus.i_div_ctrl_srcA = 64'd5; bus.i_div_ctrl_srcB = 64'd0; bus.i_div_ctrl_isword = 1'b0;
        sb.push_back(64'd5);
      end else if (c == 1) begin
        bus.i_div_ctrl_control = 2'b00; bus.i_div_ctrl_srcA = 64'd7;
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      end else if (c == 3) begin
        bus.i_div_ctrl_valid = 1'b0;
      end
      #1;
      n_run++;
      if (bus.o_div_ctrl_stall !== (c == 0 || c == 2)) begin
        n_fail++; $display("FAIL b2b_stall cycle %0d: got %b", c, bus.o_div_ctrl_stall);
      end
      n_run++;
      if (bus.o_div_ctrl_valid !== (c == 1 || c == 3)) begin
        n_fail++; $display("FAIL b2b_valid cycle %0d: got %b", c, bus.o_div_ctrl_valid);
      end
      n_run++;
      if (bus.o_div_ctrl_en !== 1'b0) begin
        n_fail++; $display("FAIL b2b_en cycle %0d: got %b want 0", c, bus.o_div_ctrl_en);
      end
      if (bus.o_div_ctrl_valid === 1'b1 && sb.size() > 0) begin
        want = sb.pop_front();
        n_run++;
        if (bus.o_div_ctrl_result !== want) begin
          n_fail++; $display("FAIL b2b_result cycle %0d: got %h want %h", c, bus.o_div_ctrl_result, want);
        end
      end
      @(negedge clk);
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_sb_empty: got %0d pending want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_flush();
    logic [63:0] want;
    bus.i_div_ctrl_valid = 1'b1; bus.i_div_ctrl_control = 2'b00; bus.i_div_ctrl_isword = 1'b0;
    bus.i_div_ctrl_srcA = -64'sd20; bus.i_div_ctrl_srcB = 64'd3;
    for (int c = 0; c <= 47; c++) begin
      bus.i_div_ctrl_flush = (c == 10);
      if (c == 10) bus.i_div_ctrl_valid = 1'b0;
      if (c == 12) begin
        bus.i_div_ctrl_valid = 1'b1; bus.i_div_ctrl_srcA = -64'sd21; bus.i_div_ctrl_srcB = 64'd4;
        sb.push_back(-64'sd5);
      end
      if (c == 46) bus.i_div_ctrl_valid = 1'b0;
      bus.i_div_ctrl_done   = (c == 40 || c == 45);
      bus.i_div_ctrl_result = (c == 45) ? -64'sd5 : 64'hDEAD_DEAD_DEAD_DEAD;
      #1;
      n_run++;
      if (bus.o_div_ctrl_en !== ((c >= 1 && c <= 40) || (c >= 42 && c <= 45))) begin
        n_fail++; $display("FAIL flush_en cycle %0d: got %b", c, bus.o_div_ctrl_en);
      end
      n_run++;
      if (bus.o_div_ctrl_stall !== (c <= 9 || (c >= 12 && c <= 45))) begin
        n_fail++; $display("FAIL flush_stall cycle %0d: got %b", c, bus.o_div_ctrl_stall);
      end
      n_run++;
      if (bus.o_div_ctrl_valid !== (c == 46)) begin
        n_fail++; $display("FAIL flush_valid cycle %0d: got %b", c, bus.o_div_ctrl_valid);
      end
      if (bus.o_div_ctrl_valid === 1'b1 && sb.size() > 0) begin
        want = sb.pop_front();
        n_run++;
        if (bus.o_div_ctrl_result !== want) begin
          n_fail++; $display("FAIL flush_result: got %h want %h", bus.o_div_ctrl_result, want);
        end
      end
      if (c == 20 || c == 42) begin
        n_run++;
        if (bus.o_div_ctrl_srcA !== ((c == 20) ? -64'sd20 : -64'sd21)) begin
          n_fail++; $display("FAIL flush_srcA cycle %0d: got %h", c, bus.o_div_ctrl_srcA);
        end
      end
      @(negedge clk);
    end
    bus.i_div_ctrl_done = 1'b0;
    n_run++;
    if (bus.o_div_ctrl_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b want 1", bus.o_div_ctrl_timeout);
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL flush_sb_empty: got %0d pending want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    bus.i_div_ctrl_valid = 1'b1; bus.i_div_ctrl_control = 2'b01; bus.i_div_ctrl_isword = 1'b0;
    bus.i_div_ctrl_srcA = 64'd50; bus.i_div_ctrl_srcB = 64'd5; bus.i_div_ctrl_done = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      #1;
      n_run++;
      if (bus.o_div_ctrl_en !== (c >= 1)) begin
        n_fail++; $display("FAIL rmid_en cycle %0d: got %b", c, bus.o_div_ctrl_en);
      end
      if (c < 20) @(negedge clk);
    end
    rstn = 1'b0;
    bus.i_div_ctrl_valid = 1'b0;
    #1;
    n_run++;
    if ({bus.o_div_ctrl_en, bus.o_div_ctrl_valid, bus.o_div_ctrl_stall, bus.o_div_ctrl_timeout} !== 4'b0 ||
        bus.o_div_ctrl_srcA !== 64'd0 || bus.o_div_ctrl_result !== 64'd0) begin
      n_fail++; $display("FAIL rmid_async: got en=%b valid=%b stall=%b to=%b srcA=%h result=%h want all 0",
        bus.o_div_ctrl_en, bus.o_div_ctrl_valid, bus.o_div_ctrl_stall, bus.o_div_ctrl_timeout,
        bus.o_div_ctrl_srcA, bus.o_div_ctrl_result);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_op("post_rst", 2'b01, 1'b0, 64'd50, 64'd5, 4, 64'd10, 64'd10);
    n_run++;
    if (bus.o_div_ctrl_timeout !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_timeout: got %b want 0", bus.o_div_ctrl_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_zero();
    test_word_zero();
    test_watchdog();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
